encryptround_engine: RTL and testbench
======================================

// Module: encryptround_engine
// PURPOSE
//  Iterative AES encrypt datapath: the forward counterpart of the decrypt round chain.
//  Accepts one 4x4 byte state per handshake and applies the initial AddRoundKey.
//  Then runs NR-1 full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) and one
//  final round (no MixColumns), one round per clock. Presents the ciphertext on a
//  valid/ready output. Round keys come from the key-schedule store through rk_idx/roundkey.
// PARAMETERS
//  NR   10   number of rounds; legal values 10, 12, 14 (AES-128/192/256); other values illegal
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-low reset (0 = reset)
//  in_valid   in   1          datain holds a plaintext block
//  in_ready   out  1          engine can accept a block
//  datain     in   [7:0][3:0][3:0]  plaintext, [row][col]; FIPS byte k -> [k%4][k/4]
//  rk_idx     out  4          round-key index requested this cycle (0..NR)
//  roundkey   in   [7:0][3:0][3:0]  round key for rk_idx, valid combinationally same cycle
//  out_valid  out  1          dataout holds a finished ciphertext
//  out_ready  in   1          consumer takes dataout
//  dataout    out  [7:0][3:0][3:0]  ciphertext, same byte mapping as datain
//  busy       out  1          1 in ROUND or FINAL
// BEHAVIOUR
//  Reset:
//   - State goes to IDLE. State register, dataout and round counter go to 0.
//   - out_valid=0, busy=0, in_ready=1.
//  Reset mid-operation discards the block in flight; no partial output ever appears.
//  FSM states: IDLE, ROUND, FINAL, DONE. Round counter cnt is 4 bits.
//  IDLE:
//   - in_ready=1, rk_idx=0.
//   - On in_valid & in_ready: st <= datain ^ roundkey[0], cnt<=1, go to ROUND.
//  ROUND:
//   - rk_idx=cnt.
//   - st <= MixColumns(ShiftRows(SubBytes(st))) ^ roundkey. Reuses the forward
//     substitutekey and diffusion modules.
//   - cnt<=cnt+1. Move to FINAL on the edge where cnt==NR-1; otherwise stay in ROUND.
//  FINAL:
//   - rk_idx=NR.
//   - dataout <= ShiftRows(SubBytes(st)) ^ roundkey. Go to DONE.
//  DONE:
//   - out_valid=1, rk_idx=0. dataout is stable while out_ready=0, held indefinitely.
//   - On out_ready: go to IDLE with out_valid=0. A new block is not accepted in that cycle.
//  in_ready=0 in ROUND, FINAL and DONE. in_valid is ignored there; no buffering or queueing.
//  Latency: accept on edge T gives out_valid=1 after edge T+NR. Minimum period is NR+2 cycles per block.
//  out_valid and in_ready are registered-state decodes only, with no combinational path
//  from in_valid/out_ready. rk_idx is a decode of state and cnt only.
//  Arithmetic:
//   - MixColumns uses GF(2^8) xtime with polynomial 0x11B.
//   - ShiftRows rotates row r left by r.
//   - All XORs are bytewise, 8-bit, with no carries.
//  Simultaneous in_valid & out_ready in DONE: only the output handshake completes.
// TESTING
//  - FIPS-197 App.B, NR=10: pt 3243f6a8885a308d313198a2e0370734, key 2b7e1516...
//    -> dataout 3925841d02dc09fbdc118597196a0b32, out_valid after exactly 10 edges.
//  - FIPS-197 App.C.1: pt 00112233445566778899aabbccddeeff, key 000102..0f
//    -> 69c4e0d86a7b0430d8cdb78070b4c55a. rk_idx sequence 0,1..9,10 checked.
//  - Hold out_ready=0 for 20 cycles in DONE -> dataout unchanged, in_ready=0, and a
//    second in_valid pulse is ignored.
//  - Back-to-back blocks with in_valid and out_ready held 1 -> one ciphertext every
//    12 cycles, both outputs correct.
//  - Assert rst=0 while cnt==5 -> out_valid=0, dataout=0, in_ready=1 asynchronously.
//    After release, App.C.1 runs again and still gives the correct result.
//  - NR=14 with the App.C.3 key schedule, pt 00112233..ff
//    -> 8ea2b7ca516745bfeafc49904b496089 after 14 edges.

Source files
------------

// File: rtl/encryptround_engine.sv
// Iterative AES encrypt engine: initial key add on accept, then one
// round per clock with round keys fetched by index from a key store.
module encryptround_engine #(
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0][3:0][7:0]   datain,
  output logic [3:0]             rk_idx,
  input  logic [3:0][3:0][7:0]   roundkey,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0][3:0][7:0]   dataout,
  output logic                   busy
);

  typedef logic [3:0][3:0][7:0] blk_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [3:0] NR_M1 = 4'(NR - 1);
  localparam logic [3:0] NR_4  = 4'(NR);

  // Byte b lives at bit offset 8*(255-b), i.e. {~b, 3'b000}
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  blk_t       r_st;
  blk_t       r_dout;
  blk_t       w_sr;
  blk_t       w_mc;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic blk_t sub_shift(input blk_t s);
    blk_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = sbox(s[r][2'(c + r)]);
    return o;
  endfunction

  function automatic blk_t mix(input blk_t s);
    blk_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = xtime(s[r][c])
                ^ xtime(s[2'(r + 1)][c])
                ^ s[2'(r + 1)][c]
                ^ s[2'(r + 2)][c]
                ^ s[2'(r + 3)][c];
    return o;
  endfunction

  assign w_sr = sub_shift(r_st);
  assign w_mc = mix(w_sr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_st    <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_st  <= datain ^ roundkey;
            r_cnt <= 4'd1;
          end
        end
        ROUND: begin
          r_st  <= w_mc ^ roundkey;
          r_cnt <= r_cnt + 4'd1;
        end
        FINAL: r_dout <= w_sr ^ roundkey;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    rk_idx = 4'd0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_next = ROUND;
      end
      ROUND: begin
        rk_idx = r_cnt;
        if (r_cnt == NR_M1) w_next = FINAL;
      end
      FINAL: begin
        rk_idx = NR_4;
        w_next = DONE;
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ROUND) || (r_state == FINAL);
  assign dataout   = r_dout;

endmodule

// File: tb/tb_encryptround_engine.sv
// FIPS-197 vectors and random blocks for the AES encrypt engine,
// compared with a byte-array AES model, at NR=10 and NR=14.
module tb_encryptround_engine;

  typedef logic [3:0][3:0][7:0] blk_t;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       iv;
  logic       ordy;
  blk_t       din;

  logic       a_iv, a_ir, a_ov, a_busy;
  logic [3:0] a_idx;
  blk_t       a_rk, a_dout;
  logic       b_iv, b_ir, b_ov, b_busy;
  logic [3:0] b_idx;
  blk_t       b_rk, b_dout;

  logic       s_ir, s_ov, s_busy;
  logic [3:0] s_idx;
  blk_t       s_dout;

  blk_t         ka [16];
  blk_t         kb [16];
  logic [127:0] xk [15];
  logic [7:0]   sbt [256];

  int n_chk;
  int n_fail;

  assign a_iv   = iv & ~sel;
  assign b_iv   = iv & sel;
  assign a_rk   = ka[a_idx];
  assign b_rk   = kb[b_idx];
  assign s_ir   = sel ? b_ir : a_ir;
  assign s_ov   = sel ? b_ov : a_ov;
  assign s_busy = sel ? b_busy : a_busy;
  assign s_idx  = sel ? b_idx : a_idx;
  assign s_dout = sel ? b_dout : a_dout;

  encryptround_engine #(.NR(10)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .datain(din),
    .rk_idx(a_idx), .roundkey(a_rk),
    .out_valid(a_ov), .out_ready(ordy), .dataout(a_dout),
    .busy(a_busy)
  );

  encryptround_engine #(.NR(14)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .datain(din),
    .rk_idx(b_idx), .roundkey(b_rk),
    .out_valid(b_ov), .out_ready(ordy), .dataout(b_dout),
    .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic blk_t to_blk(input logic [127:0] h);
    blk_t b;
    for (int k = 0; k < 16; k++) b[k % 4][k / 4] = h[127 - 8 * k -: 8];
    return b;
  endfunction

  function automatic logic [127:0] from_blk(input blk_t b);
    logic [127:0] h;
    for (int k = 0; k < 16; k++) h[127 - 8 * k -: 8] = b[k % 4][k / 4];
    return h;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  // Key schedule into xk (FIPS byte order) and the selected DUT's store
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      xk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
      if (sel) kb[r] = to_blk(xk[r]);
      else     ka[r] = to_blk(xk[r]);
    end
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] h;
    for (int k = 0; k < 16; k++)
      s[k] = pt[127 - 8 * k -: 8] ^ xk[0][127 - 8 * k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int q = 0; q < 4; q++)
        for (int c = 0; c < 4; c++)
          t[q + 4 * c] = sbt[s[q + 4 * ((c + q) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++)
          if (r < nr)
            s[4 * c + i] = gmul(t[4 * c + i], 8'h02)
                         ^ gmul(t[4 * c + (i + 1) % 4], 8'h03)
                         ^ t[4 * c + (i + 2) % 4]
                         ^ t[4 * c + (i + 3) % 4];
          else
            s[4 * c + i] = t[4 * c + i];
      for (int k = 0; k < 16; k++) s[k] ^= xk[r][127 - 8 * k -: 8];
    end
    for (int k = 0; k < 16; k++) h[127 - 8 * k -: 8] = s[k];
    return h;
  endfunction

  task automatic send(input logic [127:0] pt);
    int n = 0;
    while (!s_ir && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    din = to_blk(pt);
    iv  = 1'b1;
    @(posedge clk); #1;
    iv  = 1'b0;
  endtask

  task automatic finish_blk(input logic [127:0] exp, input int nr,
                            input bit chk_idx, input string tag);
    int j = 0;
    bit idx_ok = 1'b1;
    while (!s_ov && j < 60) begin
      if (s_idx != 4'(j + 1)) idx_ok = 1'b0;
      @(posedge clk); #1;
      j++;
    end
    check({tag, "_latency"}, 128'(j), 128'(nr));
    check({tag, "_ct"}, from_blk(s_dout), exp);
    if (chk_idx) check({tag, "_rkidx_seq"}, 128'(idx_ok), 128'(1));
  endtask

  task automatic drain(input string tag);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, "_ov_after_take"}, 128'(s_ov), 128'(0));
    check({tag, "_ir_after_take"}, 128'(s_ir), 128'(1));
  endtask

  initial begin
    logic [127:0] pt, key, exp, saved;
    logic [127:0] pts [3];
    logic [127:0] expq [$];
    int n, nacc, nout, last;
    bit bad, gap_ok;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    sel = 1'b0;
    iv = 1'b0;
    ordy = 1'b0;
    din = '0;
    for (int r = 0; r < 16; r++) begin
      ka[r] = '0;
      kb[r] = '0;
    end
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(a_ir), 128'(1));
    check("rst_out_valid", 128'(a_ov), 128'(0));
    check("rst_busy", 128'(a_busy), 128'(0));
    check("rst_dataout", from_blk(a_dout), 128'(0));
    check("rst_rk_idx", 128'(a_idx), 128'(0));
    check("rst_in_ready_nr14", 128'(b_ir), 128'(1));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    expand({KEY_B, 128'h0}, 4);
    check("model_appB", ref_enc(PT_B, 10), CT_B);
    send(PT_B);
    finish_blk(CT_B, 10, 1'b0, "appB");
    drain("appB");

    expand({KEY_C1, 128'h0}, 4);
    check("model_appC1", ref_enc(PT_C, 10), CT_C1);
    send(PT_C);
    finish_blk(CT_C1, 10, 1'b1, "appC1");

    saved = from_blk(a_dout);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        din = to_blk(rnd128());
        iv  = 1'b1;
      end
      if (i == 7) iv = 1'b0;
      @(posedge clk); #1;
      if (from_blk(a_dout) !== saved || a_ir !== 1'b0 || a_ov !== 1'b1) bad = 1'b1;
    end
    check("hold_stable", 128'(bad), 128'(0));
    check("hold_ct", from_blk(a_dout), CT_C1);
    drain("hold");
    check("hold_pulse_ignored", 128'(a_busy), 128'(0));

    for (int i = 0; i < 3; i++) pts[i] = rnd128();
    nacc = 0;
    nout = 0;
    last = -1;
    gap_ok = 1'b1;
    ordy = 1'b1;
    for (int cyc = 0; cyc < 80 && nout < 3; cyc++) begin
      if (a_ov) begin
        exp = (expq.size() > 0) ? expq.pop_front() : 'x;
        check("b2b_ct", from_blk(a_dout), exp);
        if (last >= 0 && cyc - last != 12) gap_ok = 1'b0;
        last = cyc;
        nout++;
      end
      if (a_ir) begin
        if (nacc < 3) begin
          din = to_blk(pts[nacc]);
          expq.push_back(ref_enc(pts[nacc], 10));
          iv = 1'b1;
          nacc++;
        end else begin
          iv = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    iv = 1'b0;
    ordy = 1'b0;
    check("b2b_count", 128'(nout), 128'(3));
    check("b2b_period12", 128'(gap_ok), 128'(1));

    send(PT_C);
    n = 0;
    while (a_idx != 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_cnt5", 128'(a_idx), 128'(5));
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", 128'(a_ov), 128'(0));
    check("midrst_dataout", from_blk(a_dout), 128'(0));
    check("midrst_in_ready", 128'(a_ir), 128'(1));
    check("midrst_busy", 128'(a_busy), 128'(0));
    #2 rst = 1'b1;
    @(posedge clk); #1;
    send(PT_C);
    finish_blk(CT_C1, 10, 1'b1, "postrst");
    drain("postrst");

    for (int i = 0; i < 3; i++) begin
      key = rnd128();
      pt  = rnd128();
      expand({key, 128'h0}, 4);
      exp = ref_enc(pt, 10);
      send(pt);
      finish_blk(exp, 10, 1'b0, "rnd10");
      drain("rnd10");
    end

    sel = 1'b1;
    expand(KEY_C3, 8);
    check("model_appC3", ref_enc(PT_C, 14), CT_C3);
    send(PT_C);
    finish_blk(CT_C3, 14, 1'b1, "appC3");
    drain("appC3");

    for (int i = 0; i < 2; i++) begin
      pt = rnd128();
      expand({rnd128(), rnd128()}, 8);
      exp = ref_enc(pt, 14);
      send(pt);
      finish_blk(exp, 14, 1'b1, "rnd14");
      drain("rnd14");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
